// File: rtl/corefifo_wr_ptr_gray_gen.sv
// corefifo_wr_ptr_gray_gen: write-side binary/Gray pointer, read-pointer decode and full/afull/count flags
module corefifo_wr_ptr_gray_gen #(
  parameter int ADDRWIDTH = 3,
  parameter int AFULL_VAL = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   rptr_gray_sync,
  output logic [ADDRWIDTH:0]   wptr_gray,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic                 mem_we,
  output logic                 full,
  output logic                 afull,
  output logic                 overflow,
  output logic [ADDRWIDTH:0]   wrcnt
);
  localparam int A = ADDRWIDTH;
  localparam logic [A:0] AFV = (A+1)'(AFULL_VAL);
  logic [A:0] wbin, wbin_nxt, gray_nxt, rbin, cnt_nxt, full_ptr;
  genvar i;
  generate
    for (i = 0; i <= A; i++) begin : g_dec
      assign rbin[i] = ^rptr_gray_sync[A:i];
    end
  endgenerate
  assign mem_we   = we & ~full;
  assign wbin_nxt = wbin + {{A{1'b0}}, mem_we};
  assign gray_nxt = wbin_nxt ^ (wbin_nxt >> 1);
  assign cnt_nxt  = wbin_nxt - rbin;
  assign full_ptr = {~rptr_gray_sync[A:A-1], rptr_gray_sync[A-2:0]};
  assign waddr    = wbin[A-1:0];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbin      <= '0;
      wptr_gray <= '0;
      full      <= 1'b0;
      afull     <= 1'b0;
      overflow  <= 1'b0;
      wrcnt     <= '0;
    end else begin
      wbin      <= wbin_nxt;
      wptr_gray <= gray_nxt;
      full      <= gray_nxt == full_ptr;
      afull     <= cnt_nxt >= AFV;
      overflow  <= we & full;
      wrcnt     <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_corefifo_wr_ptr_gray_gen.sv
// tb_corefifo_wr_ptr_gray_gen: directed checks of pointer, Gray output and flags at ADDRWIDTH=3, AFULL_VAL=6
module tb_corefifo_wr_ptr_gray_gen;
  logic       clk, rstn, we;
  logic [3:0] rptr_gray_sync, wptr_gray, wrcnt;
  logic [2:0] waddr;
  logic       mem_we, full, afull, overflow;
  int         checks = 0;
  int         errs = 0;
  logic [4:0] wb;
  logic [3:0] prev_g;
  logic [3:0] exp_g [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};

  corefifo_wr_ptr_gray_gen #(.ADDRWIDTH(3), .AFULL_VAL(6)) dut (
    .clk(clk), .rstn(rstn), .we(we), .rptr_gray_sync(rptr_gray_sync),
    .wptr_gray(wptr_gray), .waddr(waddr), .mem_we(mem_we), .full(full),
    .afull(afull), .overflow(overflow), .wrcnt(wrcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic test_reset;
    rstn = 1'b0; we = 1'b0; rptr_gray_sync = 4'b0000;
    #2;
    checks++;
    if ({wptr_gray, waddr, mem_we, full, afull, overflow, wrcnt} !== 15'b0) begin
      errs++; $display("FAIL reset_outputs got %b want 0", {wptr_gray, waddr, mem_we, full, afull, overflow, wrcnt});
    end
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wptr_gray, waddr, mem_we, full, afull, overflow, wrcnt} !== 15'b0) begin
      errs++; $display("FAIL post_reset_idle got %b want 0", {wptr_gray, waddr, mem_we, full, afull, overflow, wrcnt});
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) we = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b1 || waddr !== 3'(i)) begin
        errs++; $display("FAIL fill_addr[%0d] mem_we=%b waddr=%0d want 1/%0d", i, mem_we, waddr, i);
      end
      @(posedge clk);
      #1;
      checks++;
      if (wptr_gray !== exp_g[i] || wrcnt !== 4'(i + 1) || afull !== (i >= 5) || full !== (i == 7)) begin
        errs++; $display("FAIL fill[%0d] gray=%b cnt=%0d afull=%b full=%b want %b/%0d/%b/%b",
                         i, wptr_gray, wrcnt, afull, full, exp_g[i], i + 1, i >= 5, i == 7);
      end
    end
    @(negedge clk) we = 1'b0;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk) we = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b0 || waddr !== 3'd0) begin
        errs++; $display("FAIL ovf_memwe[%0d] mem_we=%b waddr=%0d want 0/0", i, mem_we, waddr);
      end
      @(posedge clk);
      #1;
      checks++;
      if (overflow !== 1'b1 || wptr_gray !== 4'b1100 || full !== 1'b1 || wrcnt !== 4'd8) begin
        errs++; $display("FAIL ovf[%0d] ovf=%b gray=%b full=%b cnt=%0d want 1/1100/1/8", i, overflow, wptr_gray, full, wrcnt);
      end
    end
    @(negedge clk) we = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      errs++; $display("FAIL ovf_end ovf=%b full=%b want 0/1", overflow, full);
    end
  endtask

  task automatic test_read_release;
    @(negedge clk) rptr_gray_sync = 4'b0001;
    @(posedge clk);
    #1;
    checks++;
    if (full !== 1'b0 || wrcnt !== 4'd7 || afull !== 1'b1) begin
      errs++; $display("FAIL release full=%b cnt=%0d afull=%b want 0/7/1", full, wrcnt, afull);
    end
    @(negedge clk) we = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (full !== 1'b1 || wrcnt !== 4'd8 || wptr_gray !== 4'b1101) begin
      errs++; $display("FAIL refill full=%b cnt=%0d gray=%b want 1/8/1101", full, wrcnt, wptr_gray);
    end
    @(negedge clk) we = 1'b0;
  endtask

  task automatic test_wrap;
    wb = 5'd9;
    rptr_gray_sync = b2g(4'd7);
    @(posedge clk);
    #1;
    checks++;
    if (full !== 1'b0 || wrcnt !== 4'd2) begin
      errs++; $display("FAIL wrap_prime full=%b cnt=%0d want 0/2", full, wrcnt);
    end
    prev_g = wptr_gray;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      we = 1'b1;
      rptr_gray_sync = b2g(4'(wb - 5'd1));
      #1;
      checks++;
      if (mem_we !== 1'b1 || waddr !== wb[2:0]) begin
        errs++; $display("FAIL wrap_addr[%0d] mem_we=%b waddr=%0d want 1/%0d", i, mem_we, waddr, wb[2:0]);
      end
      @(posedge clk);
      #1;
      wb = wb + 5'd1;
      checks++;
      if (wptr_gray !== b2g(wb[3:0]) || wrcnt !== 4'd2 || full !== 1'b0 || afull !== 1'b0) begin
        errs++; $display("FAIL wrap[%0d] gray=%b cnt=%0d full=%b afull=%b want %b/2/0/0",
                         i, wptr_gray, wrcnt, full, afull, b2g(wb[3:0]));
      end
      checks++;
      if ($countones(prev_g ^ wptr_gray) != 1) begin
        errs++; $display("FAIL gray_step[%0d] %b -> %b changes %0d bits want 1", i, prev_g, wptr_gray, $countones(prev_g ^ wptr_gray));
      end
      if (wb == 5'd16) begin
        checks++;
        if (wptr_gray !== 4'b0000 || prev_g !== 4'b1000 || waddr !== 3'd0) begin
          errs++; $display("FAIL wrap_point prev=%b gray=%b waddr=%0d want 1000/0000/0", prev_g, wptr_gray, waddr);
        end
      end
      prev_g = wptr_gray;
    end
    @(negedge clk) we = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk) we = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b0;
    we = 1'b0;
    rptr_gray_sync = 4'b0000;
    #1;
    checks++;
    if ({wptr_gray, waddr, mem_we, full, afull, overflow, wrcnt} !== 15'b0) begin
      errs++; $display("FAIL mid_reset got %b want 0", {wptr_gray, waddr, mem_we, full, afull, overflow, wrcnt});
    end
    @(negedge clk) rstn = 1'b1;
    @(negedge clk) we = 1'b1;
    #1;
    checks++;
    if (waddr !== 3'd0 || mem_we !== 1'b1) begin
      errs++; $display("FAIL first_write_addr waddr=%0d mem_we=%b want 0/1", waddr, mem_we);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wptr_gray !== 4'b0001 || wrcnt !== 4'd1) begin
      errs++; $display("FAIL first_write gray=%b cnt=%0d want 0001/1", wptr_gray, wrcnt);
    end
    @(negedge clk) we = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_read_release;
    test_wrap;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
